// File: rtl/td4_exec_unit.sv
// rtl/td4_exec_unit.sv - TD4 execute stage: decoder, operand mux, 4-bit adder, carry flag
//
// Purpose:
//   Decodes the fetched op/im pair, selects the ALU operand, adds the immediate
//   to it and produces the active-low load strobes for A, B, OUT and PC. The
//   only state is the carry flag that JNC tests.
//
// Ports:
//   clk        in   1  clock
//   rst        in   1  synchronous active-high reset
//   ce         in   1  step enable; the carry flag updates only when 1
//   op         in   4  opcode (upper instruction nibble)
//   im         in   4  immediate (lower instruction nibble)
//   reg_a      in   4  current A register value
//   reg_b      in   4  current B register value
//   in_port    in   4  external input port (used only with TD4_IN_PORT_EN)
//   sel_y      out  4  selected ALU operand
//   sum        out  4  sel_y + im, mod 16
//   cout       out  1  adder carry-out (combinational)
//   ld_n       out  4  active-low load strobes: [3]=A [2]=B [1]=OUT [0]=PC
//   carry_flag out  1  registered carry
//
// Build option:
//   TD4_IN_PORT_EN - when defined, operand IN routes in_port; otherwise IN
//                    reads as zero and in_port is ignored.

module td4_exec_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [3:0] op,
  input  logic [3:0] im,
  input  logic [3:0] reg_a,
  input  logic [3:0] reg_b,
  input  logic [3:0] in_port,
  output logic [3:0] sel_y,
  output logic [3:0] sum,
  output logic       cout,
  output logic [3:0] ld_n,
  output logic       carry_flag
);

  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } src_e;

  localparam logic [3:0] LD_NONE = 4'b1111;
  localparam logic [3:0] LD_A    = 4'b0111;
  localparam logic [3:0] LD_B    = 4'b1011;
  localparam logic [3:0] LD_OUT  = 4'b1101;
  localparam logic [3:0] LD_PC   = 4'b1110;

  src_e       src;
  logic [3:0] in_val;
  logic [4:0] add_res;

`ifdef TD4_IN_PORT_EN
  assign in_val = in_port;
`else
  // Port is not part of this build; IN behaves like MOV of the immediate.
  logic unused_in_port;
  assign unused_in_port = ^in_port;
  assign in_val = 4'b0000;
`endif

  // Instruction decode
  always_comb begin
    src  = SRC_ZERO;
    ld_n = LD_NONE;
    unique case (op)
      4'b0000: begin src = SRC_A;    ld_n = LD_A;   end  // ADD A,Im
      4'b0101: begin src = SRC_B;    ld_n = LD_B;   end  // ADD B,Im
      4'b0011: begin src = SRC_ZERO; ld_n = LD_A;   end  // MOV A,Im
      4'b0111: begin src = SRC_ZERO; ld_n = LD_B;   end  // MOV B,Im
      4'b0001: begin src = SRC_B;    ld_n = LD_A;   end  // MOV A,B
      4'b0100: begin src = SRC_A;    ld_n = LD_B;   end  // MOV B,A
      4'b0010: begin src = SRC_IN;   ld_n = LD_A;   end  // IN A
      4'b0110: begin src = SRC_IN;   ld_n = LD_B;   end  // IN B
      4'b1001: begin src = SRC_B;    ld_n = LD_OUT; end  // OUT B
      4'b1011: begin src = SRC_ZERO; ld_n = LD_OUT; end  // OUT Im
      4'b1111: begin src = SRC_ZERO; ld_n = LD_PC;  end  // JMP Im
      4'b1110: begin                                     // JNC Im
        src  = SRC_ZERO;
        ld_n = carry_flag ? LD_NONE : LD_PC;
      end
      default: begin src = SRC_ZERO; ld_n = LD_NONE; end // NOP
    endcase
  end

  // Operand selector
  always_comb begin
    sel_y = 4'b0000;
    unique case (src)
      SRC_A:    sel_y = reg_a;
      SRC_B:    sel_y = reg_b;
      SRC_IN:   sel_y = in_val;
      SRC_ZERO: sel_y = 4'b0000;
      default:  sel_y = 4'b0000;
    endcase
  end

  assign add_res = {1'b0, sel_y} + {1'b0, im};
  assign sum     = add_res[3:0];
  assign cout    = add_res[4];

  // Carry is captured on every executed instruction, so JNC sees the carry of
  // whatever ran just before it, not only of the last ADD.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_flag <= 1'b0;
    end else if (ce) begin
      carry_flag <= cout;
    end
  end

endmodule

// File: tb/tb_td4_exec_unit.sv
// tb/tb_td4_exec_unit.sv - scoreboard testbench for td4_exec_unit
module tb_td4_exec_unit;

  logic       clk;
  logic       rst;
  logic       ce;
  logic [3:0] op;
  logic [3:0] im;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic [3:0] in_port;
  logic [3:0] sel_y;
  logic [3:0] sum;
  logic       cout;
  logic [3:0] ld_n;
  logic       carry_flag;

  td4_exec_unit dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .op         (op),
    .im         (im),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .in_port    (in_port),
    .sel_y      (sel_y),
    .sum        (sum),
    .cout       (cout),
    .ld_n       (ld_n),
    .carry_flag (carry_flag)
  );

  typedef struct packed {
    logic [7:0] id;
    logic [3:0] sel_y;
    logic [3:0] sum;
    logic       cout;
    logic [3:0] ld_n;
    logic       cf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec%0d: got %b, expected %b", name, id, act, req);
    end
  endtask

  // Monitor: outputs are settled mid-cycle; compare against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("sel_y",      int'(e.id), sel_y,              e.sel_y);
      check("sum",        int'(e.id), sum,                e.sum);
      check("cout",       int'(e.id), {3'b000, cout},     {3'b000, e.cout});
      check("ld_n",       int'(e.id), ld_n,               e.ld_n);
      check("carry_flag", int'(e.id), {3'b000, carry_flag}, {3'b000, e.cf});
    end
  end

  // Apply one vector just after a rising edge and push its expected response.
  task automatic drive(input logic r, input logic c, input logic [3:0] o, input logic [3:0] i,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] p,
                       input logic [3:0] x_sel, input logic [3:0] x_sum, input logic x_cout,
                       input logic [3:0] x_ld, input logic x_cf);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ce = c; op = o; im = i; reg_a = a; reg_b = b; in_port = p;
    e.id    = vec_id[7:0];
    e.sel_y = x_sel;
    e.sum   = x_sum;
    e.cout  = x_cout;
    e.ld_n  = x_ld;
    e.cf    = x_cf;
    sb.push_back(e);
    vec_id++;
  endtask

  logic [3:0] in_a_sel, in_a_sum, in_b_sel, in_b_sum;

  initial begin
`ifdef TD4_IN_PORT_EN
    in_a_sel = 4'b0101; in_a_sum = 4'b0110;
    in_b_sel = 4'b1100; in_b_sum = 4'b1111;
`else
    in_a_sel = 4'b0000; in_a_sum = 4'b0001;
    in_b_sel = 4'b0000; in_b_sum = 4'b0011;
`endif
    // Reset cycle with an ADD that carries: reset must win over ce.
    rst = 1'b1; ce = 1'b1; op = 4'b0000; im = 4'b0001;
    reg_a = 4'b1111; reg_b = 4'b0000; in_port = 4'b0000;

    //     rst   ce    op       im       a        b        in       sel      sum      co    ld_n     cf
    drive(1'b0, 1'b0, 4'b1011, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 1'b0, 4'b1101, 1'b0); // OUT Im after reset
    drive(1'b0, 1'b1, 4'b0000, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b1, 4'b0111, 1'b0); // ADD A wraps
    drive(1'b0, 1'b1, 4'b1110, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1); // JNC, C=1: no jump
    drive(1'b0, 1'b0, 4'b1110, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 4'b1110, 1'b0); // JNC, C=0: jump
    drive(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 1'b0, 4'b0111, 1'b0); // MOV A,B
    drive(1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0011, 4'b1010, 4'b0000, 4'b0011, 4'b0011, 1'b0, 4'b1011, 1'b0); // MOV B,A
    drive(1'b0, 1'b1, 4'b0101, 4'b1111, 4'b0011, 4'b0010, 4'b0000, 4'b0010, 4'b0001, 1'b1, 4'b1011, 1'b0); // ADD B carries
    for (int k = 0; k < 3; k++)
      drive(1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0000, 4'b0001, 4'b0010, 1'b0, 4'b0111, 1'b1); // ce=0 hold
    drive(1'b0, 1'b1, 4'b1000, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b1111, 1'b1); // undefined op
    drive(1'b0, 1'b0, 4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0101, in_a_sel, in_a_sum, 1'b0, 4'b0111, 1'b0); // IN A
    drive(1'b0, 1'b0, 4'b0110, 4'b0011, 4'b0001, 4'b0010, 4'b1100, in_b_sel, in_b_sum, 1'b0, 4'b1011, 1'b0); // IN B
    drive(1'b0, 1'b0, 4'b0111, 4'b0100, 4'b1001, 4'b0010, 4'b0000, 4'b0000, 4'b0100, 1'b0, 4'b1011, 1'b0); // MOV B,Im
    drive(1'b0, 1'b0, 4'b0011, 4'b1001, 4'b1001, 4'b0010, 4'b0000, 4'b0000, 4'b1001, 1'b0, 4'b0111, 1'b0); // MOV A,Im
    drive(1'b0, 1'b0, 4'b1111, 4'b1010, 4'b1001, 4'b0010, 4'b0000, 4'b0000, 4'b1010, 1'b0, 4'b1110, 1'b0); // JMP
    drive(1'b0, 1'b0, 4'b1001, 4'b0000, 4'b1001, 4'b0110, 4'b0000, 4'b0110, 4'b0110, 1'b0, 4'b1101, 1'b0); // OUT B
    drive(1'b0, 1'b0, 4'b1100, 4'b0101, 4'b1001, 4'b0110, 4'b0000, 4'b0000, 4'b0101, 1'b0, 4'b1111, 1'b0); // NOP 1100
    drive(1'b0, 1'b1, 4'b0000, 4'b1000, 4'b1001, 4'b0110, 4'b0000, 4'b1001, 4'b0001, 1'b1, 4'b0111, 1'b0); // ADD A carries
    drive(1'b1, 1'b1, 4'b0000, 4'b1000, 4'b1001, 4'b0110, 4'b0000, 4'b1001, 4'b0001, 1'b1, 4'b0111, 1'b1); // rst over ce
    drive(1'b0, 1'b0, 4'b1011, 4'b0000, 4'b1001, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b1101, 1'b0); // cleared

    for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/td4_exec_unit.md
Name: td4_exec_unit

Overview:
- Execute stage of the TD4 4-bit CPU: instruction decoder, ALU operand selector, 4-bit adder and carry flag.
- Takes the fetched op/im pair and the current A/B register values.
- Produces the ALU result, the active-low load strobes for A, B, OUT and PC, and the registered carry flag used by JNC.
- The register file, PC and program ROM are outside this block.

Parameters:
- None. Data width is fixed at 4 bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- ce  in  1  step enable; carry flag updates only when 1
- op  in  4  opcode (upper nibble of instruction)
- im  in  4  immediate (lower nibble of instruction)
- reg_a  in  4  current A register value
- reg_b  in  4  current B register value
- in_port  in  4  external input port; used only with IN_PORT_EN
- sel_y  out  4  selected ALU operand
- sum  out  4  ALU result, sel_y + im, mod 16
- cout  out  1  adder carry-out (combinational)
- ld_n  out  4  active-low load strobes: [3]=A, [2]=B, [1]=OUT, [0]=PC
- carry_flag  out  1  registered carry (C)

Behaviour:
- Everything except carry_flag is purely combinational from op, im, reg_a, reg_b, in_port and carry_flag.
- Adder: {cout, sum} = sel_y + im as a 5-bit result. Unsigned, no saturation. Example: 1111+0001 gives sum 0000, cout 1.
- Operand selector: picks A, B, IN or ZERO as decided by the decoder.
- Decode table (op -> operand, asserted strobe; every other ld_n bit is 1):
  - 0000 ADD A,Im -> A, A
  - 0101 ADD B,Im -> B, B
  - 0011 MOV A,Im -> ZERO, A
  - 0111 MOV B,Im -> ZERO, B
  - 0001 MOV A,B -> B, A
  - 0100 MOV B,A -> A, B
  - 0010 IN A -> IN, A
  - 0110 IN B -> IN, B
  - 1001 OUT B -> B, OUT
  - 1011 OUT Im -> ZERO, OUT
  - 1111 JMP Im -> ZERO, PC
  - 1110 JNC Im -> ZERO; PC strobe asserted (0) only when carry_flag==0, otherwise ld_n=1111
- Any other opcode is a NOP: operand ZERO, ld_n=1111. The PC then increments externally.
- ld_n[0]=1 means the PC increments; ld_n[0]=0 means the PC loads sum.
- MOV A,B and MOV B,A add im to the moved value; software encodes im=0000.
- Carry flag, on rising edge of clk:
  - rst=1: carry_flag <= 0.
  - Else if ce=1: carry_flag <= cout, on every instruction, not only ADD.
  - Else: hold.
  - rst has priority over ce.
- Consequence: JNC tests the carry produced by the immediately preceding executed instruction.
- Changing op/im/reg_a/reg_b while ce=0 changes only the combinational outputs, never carry_flag.

Optional Feature:
- Macro: TD4_IN_PORT_EN.
- Defined: operand IN routes in_port, so IN A and IN B load the external port value plus im.
- Undefined: in_port is ignored. Operand IN is treated as ZERO, so IN A/IN B load im.

Test Plan:
- Reset: rst=1 for 1 clk with cout=1 -> carry_flag=0. Then op=1011 im=0111 -> sum=0111, ld_n=1101, cout=0.
- Add with wrap: op=0000 im=0001 reg_a=1111, ce=1, one clk -> sum=0000, cout=1, ld_n=0111, carry_flag=1 after the edge.
- JNC both ways:
  - carry_flag=1, op=1110 im=0001 -> ld_n=1111, sum=0001.
  - After a non-carry instruction updates carry_flag to 0, the same op -> ld_n=1110.
- Moves: op=0001 im=0 reg_b=1010 -> sum=1010, ld_n=0111. op=0100 reg_a=0011 -> sum=0011, ld_n=1011.
- Enable hold: carry_flag=1, ce=0, ADD producing cout=0 for 3 clks -> carry_flag stays 1.
- Undefined/IN: op=1000 -> ld_n=1111, sel_y=0000. op=0010 in_port=0101 im=0001 -> sum=0110 with TD4_IN_PORT_EN, 0001 without.
